// File: rtl/fpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fpu_ctrl_pkg
// Shared types for the FPU issue controller: op encoding, writeback mux
// select, reservation-table entry and divider FSM state.
// RESV_TAG_W is the tag width carried in each reservation entry; the top
// zero-extends its TAG_W tag into it, so TAG_W must not exceed RESV_TAG_W.
// -----------------------------------------------------------------------------
package fpu_ctrl_pkg;

  localparam int RESV_TAG_W = 16;

  typedef enum logic [1:0] {
    FADD = 2'd0,
    FSUB = 2'd1,
    FMUL = 2'd2,
    FDIV = 2'd3
  } fpu_op_t;

  typedef enum logic [1:0] {
    WB_ADD = 2'd0,
    WB_MUL = 2'd1,
    WB_DIV = 2'd2
  } wb_sel_t;

  typedef struct packed {
    logic                  valid;
    wb_sel_t               sel;
    logic [RESV_TAG_W-1:0] tag;
  } resv_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fpu_wb_resv.sv
// -----------------------------------------------------------------------------
// fpu_wb_resv
// Writeback reservation shift register. Slot k holds the result that will be
// written back k cycles from now; slot 0 is the head, i.e. the registered
// writeback of the current cycle. Every clock the table moves one slot toward
// the head.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous clear of every slot
//   ins_en        insert ins_entry so that it reaches the head ins_lat cycles
//                 from now (ins_lat >= 1)
//   chk_lat       latency to look up; chk_conflict=1 if that writeback cycle
//                 is already taken
//   head          current writeback entry
//   nonempty      any slot (including the head) valid
// -----------------------------------------------------------------------------
module fpu_wb_resv
  import fpu_ctrl_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             ins_en,
  input  logic [LAT_W-1:0] ins_lat,
  input  resv_entry_t      ins_entry,
  input  logic [LAT_W-1:0] chk_lat,
  output logic             chk_conflict,
  output resv_entry_t      head,
  output logic             nonempty
);

  resv_entry_t [DEPTH-1:0] slot_q;
  resv_entry_t [DEPTH-1:0] slot_d;

  // Insertion lands in the post-shift view: latency L goes to slot L-1.
  always_comb begin
    slot_d = '0;
    if (!clear) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        slot_d[k] = slot_q[k + 1];
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (ins_en && (ins_lat == LAT_W'(k + 1))) begin
          slot_d[k] = ins_entry;
        end
      end
    end
  end

  // Writeback cycle t+L is currently slot L. Slot 0 frees at this edge and a
  // latency of DEPTH reaches past anything reserved, so neither can conflict.
  always_comb begin
    chk_conflict = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if (slot_q[k].valid && (chk_lat == LAT_W'(k))) begin
        chk_conflict = 1'b1;
      end
    end
  end

  always_comb begin
    nonempty = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      nonempty = nonempty | slot_q[k].valid;
    end
  end

  assign head = slot_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
// Issue scheduler for the FPU cluster (fadd/fsub, fmul, fdiv). Accepts one op
// per cycle on a valid/ready handshake, strobes the selected unit, reserves
// the single shared writeback slot at issue time and drives the writeback mux
// select and tag. No operand or result data passes through here.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   flush                      (FPU_FLUSH_EN only) discard all in-flight ops
//   req_valid/req_op/req_tag   dispatch request; req_ready is the accept
//                              condition and never depends on req_valid
//   fadd_start/fadd_sub        fadd unit strobe, fadd_sub=1 for subtract
//   fmul_start, fdiv_start     unit strobes
//   wb_valid/wb_sel/wb_tag     registered shared-writeback control
//   busy                       any op in flight
// Optional feature: define FPU_FLUSH_EN to add the flush input.
// -----------------------------------------------------------------------------
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int FADD_LAT = 4,
  parameter int FMUL_LAT = 2,
  parameter int FDIV_LAT = 10,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FPU_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             fadd_start,
  output logic             fadd_sub,
  output logic             fmul_start,
  output logic             fdiv_start,
  output logic             wb_valid,
  output logic [1:0]       wb_sel,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy
);

  localparam int MAXLAT    = max3(FADD_LAT, FMUL_LAT, FDIV_LAT);
  localparam int LAT_W     = $clog2(MAXLAT + 1);
  localparam int DIV_CNT_W = $clog2(FDIV_LAT);

  function automatic logic [LAT_W-1:0] lat_of(input fpu_op_t o);
    case (o)
      FMUL:    return LAT_W'(FMUL_LAT);
      FDIV:    return LAT_W'(FDIV_LAT);
      default: return LAT_W'(FADD_LAT);
    endcase
  endfunction

  function automatic wb_sel_t sel_of(input fpu_op_t o);
    case (o)
      FMUL:    return WB_MUL;
      FDIV:    return WB_DIV;
      default: return WB_ADD;
    endcase
  endfunction

  fpu_op_t              op;
  logic [LAT_W-1:0]     op_lat;
  logic                 flush_w;
  logic                 conflict;
  logic                 accept;
  logic                 resv_nonempty;
  resv_entry_t          ins_entry;
  resv_entry_t          head;
  div_state_t           div_state_q, div_state_d;
  logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic                 unused_tag_bits;

`ifdef FPU_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign op     = fpu_op_t'(req_op);
  assign op_lat = lat_of(op);

  assign req_ready = !conflict && !((op == FDIV) && (div_state_q == BUSY)) && !flush_w;
  assign accept    = req_valid && req_ready;

  assign fadd_start = accept && ((op == FADD) || (op == FSUB));
  assign fadd_sub   = accept && (op == FSUB);
  assign fmul_start = accept && (op == FMUL);
  assign fdiv_start = accept && (op == FDIV);

  always_comb begin
    ins_entry       = '0;
    ins_entry.valid = 1'b1;
    ins_entry.sel   = sel_of(op);
    ins_entry.tag   = RESV_TAG_W'(req_tag);
  end

  fpu_wb_resv #(
    .DEPTH (MAXLAT),
    .LAT_W (LAT_W)
  ) u_resv (
    .clk          (clk),
    .rst          (rst),
    .clear        (flush_w),
    .ins_en       (accept),
    .ins_lat      (op_lat),
    .ins_entry    (ins_entry),
    .chk_lat      (op_lat),
    .chk_conflict (conflict),
    .head         (head),
    .nonempty     (resv_nonempty)
  );

  // Counter is loaded with FDIV_LAT-1 and leaves BUSY as it reaches 0, so the
  // divider is IDLE again exactly in the previous result's writeback cycle.
  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    case (div_state_q)
      IDLE: begin
        if (fdiv_start) begin
          div_state_d = BUSY;
          div_cnt_d   = DIV_CNT_W'(FDIV_LAT - 1);
        end
      end
      BUSY: begin
        if (div_cnt_q == DIV_CNT_W'(1)) begin
          div_state_d = IDLE;
          div_cnt_d   = '0;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      default: begin
        div_state_d = IDLE;
        div_cnt_d   = '0;
      end
    endcase
    if (flush_w) begin
      div_state_d = IDLE;
      div_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_state_q <= IDLE;
      div_cnt_q   <= '0;
    end else begin
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

  assign wb_valid = head.valid;
  assign wb_sel   = head.sel;
  assign wb_tag   = head.tag[TAG_W-1:0];
  assign busy     = resv_nonempty || (div_state_q == BUSY);

  // Upper tag bits are always zero-extension; fold them so they count as read.
  assign unused_tag_bits = ^head.tag;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'd0;
  logic [4:0] req_tag = 5'd0;
  logic       req_ready, fadd_start, fadd_sub, fmul_start, fdiv_start;
  logic       wb_valid, busy;
  logic [1:0] wb_sel;
  logic [4:0] wb_tag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
`ifdef FPU_FLUSH_EN
    .flush      (flush),
`endif
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .req_ready  (req_ready),
    .fadd_start (fadd_start),
    .fadd_sub   (fadd_sub),
    .fmul_start (fmul_start),
    .fdiv_start (fdiv_start),
    .wb_valid   (wb_valid),
    .wb_sel     (wb_sel),
    .wb_tag     (wb_tag),
    .busy       (busy)
  );

  task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] tag);
    req_valid = v;
    req_op    = op;
    req_tag   = tag;
  endtask

  // Leaves the bench at posedge+1 of cycle 0 with reset released.
  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    drive(1'b0, 2'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({wb_valid, wb_sel, wb_tag, fadd_start, fadd_sub, fmul_start, fdiv_start, busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {wb_valid, wb_sel, wb_tag, fadd_start, fadd_sub, fmul_start, fdiv_start, busy});
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", req_ready);
    end
    next_cycle();
    // three ops in flight: fadd tag1 (t0), fdiv tag2 (t1), fadd tag3 (t2)
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       drive(1'b1, 2'd0, 5'd1);
        1:       drive(1'b1, 2'd3, 5'd2);
        default: drive(1'b1, 2'd0, 5'd3);
      endcase
      next_cycle();
    end
    drive(1'b0, 2'd0, 5'd0);
    rst = 1'b1;
    #1;
    checks++;
    if ({wb_valid, busy, req_ready} !== 3'b001) begin
      failures++;
      $display("FAIL reset_midrun got=%b exp=001", {wb_valid, busy, req_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 14; t++) begin
      #1;
      checks++;
      if (wb_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_discard t=%0d wb_valid=%b busy=%b ready=%b exp 0/0/1", t, wb_valid, busy, req_ready);
      end
      next_cycle();
    end
  endtask

  task automatic test_order();
    logic       ev;
    logic [1:0] es;
    logic [4:0] et;
    do_reset();
    for (int t = 0; t < 8; t++) begin
      case (t)
        0:       drive(1'b1, 2'd2, 5'd3);
        1:       drive(1'b1, 2'd0, 5'd4);
        default: drive(1'b0, 2'd0, 5'd0);
      endcase
      #1;
      if (t == 0) begin
        checks++;
        if (req_ready !== 1'b1 || fmul_start !== 1'b1 || fadd_start !== 1'b0) begin
          failures++;
          $display("FAIL order_fmul_issue ready=%b fmul=%b fadd=%b exp 1/1/0", req_ready, fmul_start, fadd_start);
        end
      end
      if (t == 1) begin
        checks++;
        if (req_ready !== 1'b1 || fadd_start !== 1'b1 || fadd_sub !== 1'b0) begin
          failures++;
          $display("FAIL order_fadd_issue ready=%b fadd=%b sub=%b exp 1/1/0", req_ready, fadd_start, fadd_sub);
        end
      end
      ev = (t == 2) || (t == 5);
      es = (t == 2) ? 2'd1 : 2'd0;
      et = (t == 2) ? 5'd3 : 5'd4;
      checks++;
      if (wb_valid !== ev || (ev && (wb_sel !== es || wb_tag !== et))) begin
        failures++;
        $display("FAIL order_wb t=%0d got v=%b sel=%0d tag=%0d exp v=%b sel=%0d tag=%0d", t, wb_valid, wb_sel, wb_tag, ev, es, et);
      end
      next_cycle();
    end
  endtask

  task automatic test_conflict();
    logic       ev;
    logic [1:0] es;
    logic [4:0] et;
    do_reset();
    for (int t = 0; t < 8; t++) begin
      case (t)
        0:       drive(1'b1, 2'd0, 5'd5);
        2, 3:    drive(1'b1, 2'd2, 5'd6);
        default: drive(1'b0, 2'd0, 5'd0);
      endcase
      #1;
      if (t == 2) begin
        checks++;
        if (req_ready !== 1'b0 || fmul_start !== 1'b0) begin
          failures++;
          $display("FAIL conflict_block ready=%b fmul=%b exp 0/0", req_ready, fmul_start);
        end
      end
      if (t == 3) begin
        checks++;
        if (req_ready !== 1'b1 || fmul_start !== 1'b1) begin
          failures++;
          $display("FAIL conflict_retry ready=%b fmul=%b exp 1/1", req_ready, fmul_start);
        end
      end
      ev = (t == 4) || (t == 5);
      es = (t == 4) ? 2'd0 : 2'd1;
      et = (t == 4) ? 5'd5 : 5'd6;
      checks++;
      if (wb_valid !== ev || (ev && (wb_sel !== es || wb_tag !== et))) begin
        failures++;
        $display("FAIL conflict_wb t=%0d got v=%b sel=%0d tag=%0d exp v=%b sel=%0d tag=%0d", t, wb_valid, wb_sel, wb_tag, ev, es, et);
      end
      next_cycle();
    end
  endtask

  task automatic test_fdiv();
    logic       ev, er;
    logic [4:0] et;
    do_reset();
    for (int t = 0; t < 23; t++) begin
      if (t == 0)       drive(1'b1, 2'd3, 5'd7);
      else if (t <= 10) drive(1'b1, 2'd3, 5'd8);
      else              drive(1'b0, 2'd0, 5'd0);
      #1;
      if (t <= 10) begin
        er = (t == 0) || (t == 10);
        checks++;
        if (req_ready !== er || fdiv_start !== er) begin
          failures++;
          $display("FAIL fdiv_ready t=%0d ready=%b start=%b exp %b", t, req_ready, fdiv_start, er);
        end
      end
      ev = (t == 10) || (t == 20);
      et = (t == 10) ? 5'd7 : 5'd8;
      checks++;
      if (wb_valid !== ev || (ev && (wb_sel !== 2'd2 || wb_tag !== et))) begin
        failures++;
        $display("FAIL fdiv_wb t=%0d got v=%b sel=%0d tag=%0d exp v=%b sel=2 tag=%0d", t, wb_valid, wb_sel, wb_tag, ev, et);
      end
      if (t == 5 || t == 21) begin
        checks++;
        if (busy !== (t == 5)) begin
          failures++;
          $display("FAIL fdiv_busy t=%0d got=%b exp=%b", t, busy, (t == 5));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic       ev;
    logic [4:0] et;
    do_reset();
    for (int t = 0; t < 14; t++) begin
      if (t < 8) drive(1'b1, (t % 2 == 1) ? 2'd1 : 2'd0, 5'(10 + t));
      else       drive(1'b0, 2'd0, 5'd0);
      #1;
      if (t < 8) begin
        checks++;
        if (req_ready !== 1'b1 || fadd_start !== 1'b1 || fadd_sub !== (t % 2 == 1)) begin
          failures++;
          $display("FAIL b2b_issue t=%0d ready=%b start=%b sub=%b exp 1/1/%b", t, req_ready, fadd_start, fadd_sub, (t % 2 == 1));
        end
      end
      ev = (t >= 4) && (t <= 11);
      et = 5'(10 + t - 4);
      checks++;
      if (wb_valid !== ev || (ev && (wb_sel !== 2'd0 || wb_tag !== et))) begin
        failures++;
        $display("FAIL b2b_wb t=%0d got v=%b sel=%0d tag=%0d exp v=%b sel=0 tag=%0d", t, wb_valid, wb_sel, wb_tag, ev, et);
      end
      next_cycle();
    end
  endtask

`ifdef FPU_FLUSH_EN
  task automatic test_flush();
    logic ev;
    do_reset();
    for (int t = 0; t < 16; t++) begin
      flush = (t == 3);
      case (t)
        0:       drive(1'b1, 2'd3, 5'd9);
        1:       drive(1'b1, 2'd0, 5'd11);
        3:       drive(1'b1, 2'd0, 5'd13);
        4:       drive(1'b1, 2'd3, 5'd12);
        default: drive(1'b0, 2'd0, 5'd0);
      endcase
      #1;
      if (t == 3) begin
        checks++;
        if (req_ready !== 1'b0 || fadd_start !== 1'b0) begin
          failures++;
          $display("FAIL flush_ready ready=%b fadd=%b exp 0/0", req_ready, fadd_start);
        end
      end
      if (t == 4) begin
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || fdiv_start !== 1'b1) begin
          failures++;
          $display("FAIL flush_after busy=%b ready=%b fdiv=%b exp 0/1/1", busy, req_ready, fdiv_start);
        end
      end
      ev = (t == 14);
      checks++;
      if (wb_valid !== ev || (ev && wb_tag !== 5'd12)) begin
        failures++;
        $display("FAIL flush_wb t=%0d got v=%b tag=%0d exp v=%b tag=12", t, wb_valid, wb_tag, ev);
      end
      next_cycle();
    end
    flush = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_order();
    test_conflict();
    test_fdiv();
    test_back_to_back();
`ifdef FPU_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
